muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage. Executes MULT, MULTU, DIV and DIVU, and holds the architectural HI/LO registers.
- Launched from the ID/EX register. Exports `busy` to the hazard unit, which stalls F/D and flushes E while a dependent MFHI/MFLO or a new mult/div sits in decode.
- Results are read from the HI/LO outputs by the EX-stage result mux.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits and the iteration count is WIDTH.

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  launch operation (single-cycle pulse from EX, already qualified by FlushE)
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
srca  input  WIDTH  rs operand (multiplicand / dividend)
srcb  input  WIDTH  rt operand (multiplier / divisor)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  WIDTH  MTHI/MTLO data
busy  output  1  operation in progress; to hazard unit
done  output  1  one-cycle pulse: HI/LO just updated by an operation
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset, asynchronous on rst_n low, takes effect immediately:
  - state=IDLE, count=0, hi=0, lo=0, done=0.
  - busy=0 (busy is decoded from state).
- FSM states: IDLE, CALC, FIX. busy = (state != IDLE), combinational from state only.
- IDLE, start=1 at edge N:
  - Latch op and the sign flags sa=srca[MSB], sb=srcb[MSB]. Sign flags are used only for op 00/10.
  - Latch magnitudes: two's-complement abs for signed ops, raw values for unsigned ops.
  - Clear the accumulator; set count=0; go to CALC.
- CALC, edges N+1..N+WIDTH, one iteration per edge; count increments and CALC→FIX at count==WIDTH-1.
  - Multiply: shift-add radix-2 on the 2*WIDTH accumulator {acc_hi, multiplier}. If LSB=1, add the multiplicand to acc_hi with a WIDTH+1-bit carry, then shift right 1.
  - Divide: restoring. Shift {rem, quotient} left 1, trial-subtract the divisor from rem in WIDTH+1 bits. If non-negative, keep the result and set quotient LSB=1; otherwise restore.
- FIX, edge N+WIDTH+1: write hi/lo, go to IDLE, done=1 for exactly the following cycle.
  - Mult: {hi,lo} = 64-bit product, negated if signed and sa^sb.
  - Div: lo = quotient, negated if signed and sa^sb; hi = remainder, negated if signed and sa.
- Total latency: start sampled at edge N, results visible after edge N+WIDTH+1 (N+33 at the default). busy is high for WIDTH+1 cycles.
- Divide by zero (srcb==0, any div op): no exception. FIX writes hi=srca as originally presented, lo=all ones.
- Signed overflow 0x80000000 / -1: lo=0x80000000, hi=0. This falls out of the magnitude algorithm and needs no special case.
- MTHI/MTLO:
  - In IDLE, hi_we/lo_we write wdata to hi/lo at the edge. Both may be asserted the same cycle.
  - While busy, they are ignored.
  - Simultaneous start with hi_we/lo_we in IDLE: start wins and the writes are dropped.
- start while busy is ignored; the current operation is unaffected. The hazard unit prevents this by design.
- Outside FIX, hi/lo change only via MT writes or reset.
- Reset mid-operation aborts immediately: no partial result is written and hi/lo are 0.

Test Plan:
- MULT srca=0xFFFFFFFD (-3), srcb=5 → busy high 33 cycles, done pulse at cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then DIVU 100/7 → lo=0x0000000E, hi=0x00000002.
- DIV -7/2 (0xFFFFFFF9, 2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 5/0 → hi=0x00000005, lo=0xFFFFFFFF, no hang: busy drops after 33 cycles.
- MTHI 0x1234 and MTLO 0x5678 in IDLE → hi=0x1234, lo=0x5678 next cycle. Then MTHI 0xAAAA while busy → ignored, final hi equals the operation result. start plus hi_we in the same IDLE cycle → the write is dropped.
- Start MULT 3×4, assert rst_n=0 at cycle 10 → busy=0, hi=lo=0 immediately. Release rst_n, restart MULT 3×4 → hi=0, lo=0x0000000C at the expected latency.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Launch/result bundle between the EX stage and the iterative multiply/divide unit.
// The EX stage is the master; muldiv_unit is the slave.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, srca, srcb, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, srca, srcb, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns the architectural HI/LO registers.
// One radix-2 step per cycle on operand magnitudes; signs are reapplied in FIX.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    count_q;
    logic [1:0]       op_q;
    logic             sa_q;
    logic             sb_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    logic             signedIn;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH:0]   divTrial;
    logic             signedOp;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] productFix;
    logic [WIDTH-1:0] quotFix;
    logic [WIDTH-1:0] remFix;

    // op[0]==0 selects the signed variants (MULT, DIV).
    assign signedIn = ~bus.op[0];
    assign absA     = (signedIn && bus.srca[WIDTH-1]) ? -bus.srca : bus.srca;
    assign absB     = (signedIn && bus.srcb[WIDTH-1]) ? -bus.srcb : bus.srcb;

    assign mulSum   = {1'b0, acc_q} + (shift_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign divShift = {acc_q, shift_q[WIDTH-1]};
    assign divTrial = divShift - {1'b0, opnd_q};

    assign signedOp   = ~op_q[0];
    assign product    = {acc_q, shift_q};
    assign productFix = (signedOp && (sa_q ^ sb_q)) ? -product : product;
    // A zero divisor leaves the dividend as remainder; only the quotient needs forcing.
    assign quotFix    = (opnd_q == '0) ? {WIDTH{1'b1}} :
                        ((signedOp && (sa_q ^ sb_q)) ? -shift_q : shift_q);
    assign remFix     = (signedOp && sa_q) ? -acc_q : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            shift_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        sa_q    <= bus.srca[WIDTH-1];
                        sb_q    <= bus.srcb[WIDTH-1];
                        acc_q   <= '0;
                        count_q <= '0;
                        // Divide keeps the divisor in opnd and shifts the dividend out as quotient.
                        if (bus.op[1]) begin
                            opnd_q  <= absB;
                            shift_q <= absA;
                        end else begin
                            opnd_q  <= absA;
                            shift_q <= absB;
                        end
                        state_q <= CALC;
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wdata;
                        if (bus.lo_we) lo_q <= bus.wdata;
                    end
                end
                CALC: begin
                    if (op_q[1]) begin
                        if (!divTrial[WIDTH]) begin
                            acc_q <= divTrial[WIDTH-1:0];
                        end else begin
                            acc_q <= divShift[WIDTH-1:0];
                        end
                        shift_q <= {shift_q[WIDTH-2:0], ~divTrial[WIDTH]};
                    end else begin
                        acc_q   <= mulSum[WIDTH:1];
                        shift_q <= {mulSum[0], shift_q[WIDTH-1:1]};
                    end
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (op_q[1]) begin
                        hi_q <= remFix;
                        lo_q <= quotFix;
                    end else begin
                        hi_q <= productFix[2*WIDTH-1:WIDTH];
                        lo_q <= productFix[WIDTH-1:0];
                    end
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam int LAT = W + 1;
    localparam int BOUND = 200;

    logic clk;
    logic rst_n;
    int   nVec;
    int   nErr;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result {hi, lo} from the architectural definition using wide integer arithmetic.
    function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (o)
            2'b00: p = sa * sb;
            2'b01: p = {32'b0, a} * {32'b0, b};
            default: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else if (o == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end else begin
                    p = {a % b, a / b};
                end
            end
        endcase
        return p;
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Pulses start for one cycle, then counts busy cycles until the unit returns to idle.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int busyCyc, output logic doneAt, output logic doneAfter,
                          output logic [31:0] hiV, output logic [31:0] loV);
        bus.op    = o;
        bus.srca  = a;
        bus.srcb  = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busyCyc = 0;
        while (bus.busy === 1'b1 && busyCyc < BOUND) begin
            busyCyc++;
            @(posedge clk); #1;
        end
        doneAt = bus.done;
        hiV    = bus.hi;
        loV    = bus.lo;
        @(posedge clk); #1;
        doneAfter = bus.done;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.srca  = '0;
        bus.srcb  = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        #12;
        nVec++; if (bus.busy !== 1'b0) begin nErr++; $display("[TB] FAIL reset_busy: got %b, expected 0", bus.busy); end
        nVec++; if (bus.done !== 1'b0) begin nErr++; $display("[TB] FAIL reset_done: got %b, expected 0", bus.done); end
        nVec++; if (bus.hi !== 32'h0) begin nErr++; $display("[TB] FAIL reset_hi: got %h, expected 0", bus.hi); end
        nVec++; if (bus.lo !== 32'h0) begin nErr++; $display("[TB] FAIL reset_lo: got %h, expected 0", bus.lo); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult_signed();
        int bc; logic d0, d1; logic [31:0] h, l;
        launch(2'b00, 32'hFFFF_FFFD, 32'd5, bc, d0, d1, h, l);
        nVec++; if (bc != LAT) begin nErr++; $display("[TB] FAIL mult_busy_cycles: got %0d, expected %0d", bc, LAT); end
        nVec++; if (d0 !== 1'b1) begin nErr++; $display("[TB] FAIL mult_done_pulse: got %b, expected 1", d0); end
        nVec++; if (d1 !== 1'b0) begin nErr++; $display("[TB] FAIL mult_done_width: got %b, expected 0", d1); end
        nVec++; if (h !== 32'hFFFF_FFFF) begin nErr++; $display("[TB] FAIL mult_hi: got %h, expected ffffffff", h); end
        nVec++; if (l !== 32'hFFFF_FFF1) begin nErr++; $display("[TB] FAIL mult_lo: got %h, expected fffffff1", l); end
    endtask

    task automatic test_multu_divu();
        int bc; logic d0, d1; logic [31:0] h, l;
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, d0, d1, h, l);
        nVec++; if (h !== 32'hFFFF_FFFE) begin nErr++; $display("[TB] FAIL multu_hi: got %h, expected fffffffe", h); end
        nVec++; if (l !== 32'h0000_0001) begin nErr++; $display("[TB] FAIL multu_lo: got %h, expected 00000001", l); end
        launch(2'b11, 32'd100, 32'd7, bc, d0, d1, h, l);
        nVec++; if (bc != LAT) begin nErr++; $display("[TB] FAIL divu_busy_cycles: got %0d, expected %0d", bc, LAT); end
        nVec++; if (l !== 32'h0000_000E) begin nErr++; $display("[TB] FAIL divu_lo: got %h, expected 0000000e", l); end
        nVec++; if (h !== 32'h0000_0002) begin nErr++; $display("[TB] FAIL divu_hi: got %h, expected 00000002", h); end
    endtask

    task automatic test_div_signed();
        int bc; logic d0, d1; logic [31:0] h, l;
        launch(2'b10, 32'hFFFF_FFF9, 32'd2, bc, d0, d1, h, l);
        nVec++; if (l !== 32'hFFFF_FFFD) begin nErr++; $display("[TB] FAIL div_neg_lo: got %h, expected fffffffd", l); end
        nVec++; if (h !== 32'hFFFF_FFFF) begin nErr++; $display("[TB] FAIL div_neg_hi: got %h, expected ffffffff", h); end
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, bc, d0, d1, h, l);
        nVec++; if (l !== 32'h8000_0000) begin nErr++; $display("[TB] FAIL div_ovf_lo: got %h, expected 80000000", l); end
        nVec++; if (h !== 32'h0000_0000) begin nErr++; $display("[TB] FAIL div_ovf_hi: got %h, expected 00000000", h); end
        launch(2'b10, 32'd7, 32'hFFFF_FFFE, bc, d0, d1, h, l);
        nVec++; if (l !== 32'hFFFF_FFFD) begin nErr++; $display("[TB] FAIL div_negdiv_lo: got %h, expected fffffffd", l); end
        nVec++; if (h !== 32'h0000_0001) begin nErr++; $display("[TB] FAIL div_negdiv_hi: got %h, expected 00000001", h); end
    endtask

    task automatic test_div_zero();
        int bc; logic d0, d1; logic [31:0] h, l;
        launch(2'b11, 32'd5, 32'd0, bc, d0, d1, h, l);
        nVec++; if (bc != LAT) begin nErr++; $display("[TB] FAIL divz_busy_cycles: got %0d, expected %0d", bc, LAT); end
        nVec++; if (h !== 32'h0000_0005) begin nErr++; $display("[TB] FAIL divz_hi: got %h, expected 00000005", h); end
        nVec++; if (l !== 32'hFFFF_FFFF) begin nErr++; $display("[TB] FAIL divz_lo: got %h, expected ffffffff", l); end
        launch(2'b10, 32'hFFFF_FFFB, 32'd0, bc, d0, d1, h, l);
        nVec++; if (h !== 32'hFFFF_FFFB) begin nErr++; $display("[TB] FAIL divz_signed_hi: got %h, expected fffffffb", h); end
        nVec++; if (l !== 32'hFFFF_FFFF) begin nErr++; $display("[TB] FAIL divz_signed_lo: got %h, expected ffffffff", l); end
    endtask

    task automatic test_mt_writes();
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_1234;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        nVec++; if (bus.hi !== 32'h0000_1234) begin nErr++; $display("[TB] FAIL mthi: got %h, expected 00001234", bus.hi); end
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_5678;
        @(posedge clk); #1;
        bus.lo_we = 1'b0;
        nVec++; if (bus.lo !== 32'h0000_5678) begin nErr++; $display("[TB] FAIL mtlo: got %h, expected 00005678", bus.lo); end
        nVec++; if (bus.hi !== 32'h0000_1234) begin nErr++; $display("[TB] FAIL mtlo_hi_kept: got %h, expected 00001234", bus.hi); end
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        nVec++; if (bus.hi !== 32'hCAFE_F00D) begin nErr++; $display("[TB] FAIL mt_both_hi: got %h, expected cafef00d", bus.hi); end
        nVec++; if (bus.lo !== 32'hCAFE_F00D) begin nErr++; $display("[TB] FAIL mt_both_lo: got %h, expected cafef00d", bus.lo); end
    endtask

    task automatic test_mt_while_busy();
        int n;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_5555;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.op    = 2'b11;
        bus.srca  = 32'd100;
        bus.srcb  = 32'd7;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_AAAA;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        nVec++; if (bus.hi !== 32'h0000_5555) begin nErr++; $display("[TB] FAIL mt_busy_hi_held: got %h, expected 00005555", bus.hi); end
        nVec++; if (bus.lo !== 32'h0000_5555) begin nErr++; $display("[TB] FAIL mt_busy_lo_held: got %h, expected 00005555", bus.lo); end
        n = 0;
        while (bus.busy === 1'b1 && n < BOUND) begin n++; @(posedge clk); #1; end
        nVec++; if (n >= BOUND) begin nErr++; $display("[TB] FAIL mt_busy_timeout: got %0d cycles, expected < %0d", n, BOUND); end
        nVec++; if (bus.hi !== 32'h0000_0002) begin nErr++; $display("[TB] FAIL mt_busy_result_hi: got %h, expected 00000002", bus.hi); end
        nVec++; if (bus.lo !== 32'h0000_000E) begin nErr++; $display("[TB] FAIL mt_busy_result_lo: got %h, expected 0000000e", bus.lo); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_with_write();
        int n;
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_1111;
        @(posedge clk); #1;
        bus.wdata = 32'h0000_2222;
        bus.op    = 2'b01;
        bus.srca  = 32'd6;
        bus.srcb  = 32'd7;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        nVec++; if (bus.hi !== 32'h0000_1111) begin nErr++; $display("[TB] FAIL start_wins_hi: got %h, expected 00001111", bus.hi); end
        nVec++; if (bus.busy !== 1'b1) begin nErr++; $display("[TB] FAIL start_wins_busy: got %b, expected 1", bus.busy); end
        n = 0;
        while (bus.busy === 1'b1 && n < BOUND) begin n++; @(posedge clk); #1; end
        nVec++; if (n != LAT) begin nErr++; $display("[TB] FAIL start_wins_cycles: got %0d, expected %0d", n, LAT); end
        nVec++; if (bus.lo !== 32'd42) begin nErr++; $display("[TB] FAIL start_wins_lo: got %h, expected 0000002a", bus.lo); end
        nVec++; if (bus.hi !== 32'd0) begin nErr++; $display("[TB] FAIL start_wins_result_hi: got %h, expected 00000000", bus.hi); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_while_busy();
        int n;
        bus.op    = 2'b00;
        bus.srca  = 32'd9;
        bus.srcb  = 32'hFFFF_FFFE;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        bus.op    = 2'b11;
        bus.srca  = 32'd50;
        bus.srcb  = 32'd3;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 5;
        while (bus.busy === 1'b1 && n < BOUND) begin n++; @(posedge clk); #1; end
        nVec++; if (n != LAT) begin nErr++; $display("[TB] FAIL ignore_start_cycles: got %0d, expected %0d", n, LAT); end
        nVec++; if (bus.hi !== 32'hFFFF_FFFF) begin nErr++; $display("[TB] FAIL ignore_start_hi: got %h, expected ffffffff", bus.hi); end
        nVec++; if (bus.lo !== 32'hFFFF_FFEE) begin nErr++; $display("[TB] FAIL ignore_start_lo: got %h, expected ffffffee", bus.lo); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops [3] = '{2'b10, 2'b00, 2'b11};
        logic [31:0] as  [3] = '{32'hFFFF_FF9C, 32'h0001_0000, 32'hDEAD_BEEF};
        logic [31:0] bs  [3] = '{32'd7, 32'h0001_0000, 32'd16};
        logic [63:0] exp;
        int n;
        for (int i = 0; i < 3; i++) begin
            exp       = refModel(ops[i], as[i], bs[i]);
            bus.op    = ops[i];
            bus.srca  = as[i];
            bus.srcb  = bs[i];
            bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            n = 0;
            while (bus.busy === 1'b1 && n < BOUND) begin n++; @(posedge clk); #1; end
            nVec++; if (n != LAT) begin nErr++; $display("[TB] FAIL b2b_cycles[%0d]: got %0d, expected %0d", i, n, LAT); end
            nVec++; if (bus.done !== 1'b1) begin nErr++; $display("[TB] FAIL b2b_done[%0d]: got %b, expected 1", i, bus.done); end
            nVec++; if ({bus.hi, bus.lo} !== exp) begin nErr++; $display("[TB] FAIL b2b_result[%0d]: got %h, expected %h", i, {bus.hi, bus.lo}, exp); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort_reset();
        int bc; logic d0, d1; logic [31:0] h, l;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.op    = 2'b00;
        bus.srca  = 32'd3;
        bus.srcb  = 32'd4;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        nVec++; if (bus.busy !== 1'b0) begin nErr++; $display("[TB] FAIL abort_busy: got %b, expected 0", bus.busy); end
        nVec++; if (bus.hi !== 32'h0) begin nErr++; $display("[TB] FAIL abort_hi: got %h, expected 0", bus.hi); end
        nVec++; if (bus.lo !== 32'h0) begin nErr++; $display("[TB] FAIL abort_lo: got %h, expected 0", bus.lo); end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        launch(2'b00, 32'd3, 32'd4, bc, d0, d1, h, l);
        nVec++; if (bc != LAT) begin nErr++; $display("[TB] FAIL restart_cycles: got %0d, expected %0d", bc, LAT); end
        nVec++; if (d0 !== 1'b1) begin nErr++; $display("[TB] FAIL restart_done: got %b, expected 1", d0); end
        nVec++; if (h !== 32'h0) begin nErr++; $display("[TB] FAIL restart_hi: got %h, expected 0", h); end
        nVec++; if (l !== 32'h0000_000C) begin nErr++; $display("[TB] FAIL restart_lo: got %h, expected 0000000c", l); end
    endtask

    task automatic test_random();
        int bc; logic d0, d1; logic [31:0] h, l, a, b;
        logic [1:0] o;
        logic [63:0] exp;
        for (int i = 0; i < 60; i++) begin
            o   = 2'($urandom_range(0, 3));
            a   = pickOperand();
            b   = pickOperand();
            exp = refModel(o, a, b);
            launch(o, a, b, bc, d0, d1, h, l);
            nVec++; if (bc != LAT) begin nErr++; $display("[TB] FAIL rand_cycles[%0d]: got %0d, expected %0d", i, bc, LAT); end
            nVec++; if ({d0, d1} !== 2'b10) begin nErr++; $display("[TB] FAIL rand_done[%0d]: got %b, expected 10", i, {d0, d1}); end
            nVec++; if ({h, l} !== exp) begin nErr++; $display("[TB] FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h, expected %h", i, o, a, b, {h, l}, exp); end
        end
    endtask

    initial begin
        nVec = 0;
        nErr = 0;
        test_reset();
        test_mult_signed();
        test_multu_divu();
        test_div_signed();
        test_div_zero();
        test_mt_writes();
        test_mt_while_busy();
        test_start_with_write();
        test_start_while_busy();
        test_back_to_back();
        test_abort_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
